// File: rtl/apb_requester.sv
// APB3 requester: turns a single-outstanding command/response handshake into
// one APB transfer at a time, with wait states, slave errors and an optional access timeout.
module apb_requester #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              i_pclk,
  input  logic              i_rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_write,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [DATA_W-1:0] i_cmd_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_psel,
  output logic              o_penable,
  output logic              o_pwrite,
  output logic [ADDR_W-1:0] o_paddr,
  output logic [DATA_W-1:0] o_pwdata,
  input  logic [DATA_W-1:0] i_prdata,
  input  logic              i_pready,
  input  logic              i_pslverr
);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_tmo;

  // Fires on the ACCESS cycle whose stall would bring the count up to TIMEOUT.
  assign w_tmo       = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));
  assign o_cmd_ready = (r_state == IDLE);

  always_ff @(posedge i_pclk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      o_psel      <= 1'b0;
      o_penable   <= 1'b0;
      o_pwrite    <= 1'b0;
      o_paddr     <= '0;
      o_pwdata    <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= '0;
      o_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_cmd_valid) begin
            r_state  <= SETUP;
            o_psel   <= 1'b1;
            o_pwrite <= i_cmd_write;
            o_paddr  <= {i_cmd_addr[ADDR_W-1:2], 2'b00};
            o_pwdata <= i_cmd_write ? i_cmd_wdata : '0;
          end
        end
        SETUP: begin
          r_state   <= ACCESS;
          o_penable <= 1'b1;
        end
        ACCESS: begin
          if (i_pready || w_tmo) begin
            r_state     <= RESP;
            o_psel      <= 1'b0;
            o_penable   <= 1'b0;
            o_pwrite    <= 1'b0;
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= i_pready ? i_pslverr : 1'b1;
            o_rsp_rdata <= (i_pready && !o_pwrite && !i_pslverr) ? i_prdata : '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            r_state     <= IDLE;
            o_rsp_valid <= 1'b0;
            r_cnt       <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/apb_requester.md
Name: apb_requester

Overview:
- APB3 requester (master) that turns a simple command/response handshake into single APB transfers on the peripheral bus.
- Sits between a register-access client (sequencer shim, CPU-side bridge) and APB completers such as the example register/memory block.
- Handles one outstanding transfer, wait states (pready), error responses (pslverr) and an optional access timeout.

Parameters:
- ADDR_W, 16, APB address width.
- DATA_W, 32, APB data width.
- TIMEOUT, 64, max ACCESS-phase cycles before forced error termination; 0 disables timeout.

Ports:
- pclk  input  1  APB clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  requester can accept a command.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  ADDR_W  byte address.
- cmd_wdata  input  DATA_W  write data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  client accepts the response.
- rsp_rdata  output  DATA_W  read data; 0 for writes and errors.
- rsp_err  output  1  pslverr seen or timeout.
- psel  output  1  APB select.
- penable  output  1  APB enable.
- pwrite  output  1  APB direction.
- paddr  output  ADDR_W  APB address.
- pwdata  output  DATA_W  APB write data.
- prdata  input  DATA_W  APB read data.
- pready  input  1  completer ready; tie high for zero-wait completers.
- pslverr  input  1  completer error; tie low if unused.

Behaviour:
- Reset (async assert, sync release): state=IDLE; psel, penable, pwrite, rsp_valid and rsp_err are 0; paddr, pwdata and rsp_rdata are 0; timeout counter is 0.
- Reset mid-transfer drops psel/penable immediately; any pending response is discarded.
- cmd_ready = (state==IDLE), combinational from state only.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - On cmd_valid && cmd_ready: register cmd_write, cmd_addr and cmd_wdata, then go to SETUP.
  - Next-cycle outputs: psel=1, penable=0.
  - paddr = {cmd_addr[ADDR_W-1:2], 2'b00}; misaligned low bits are silently cleared.
  - pwdata = cmd_wdata for writes, 0 for reads.
- SETUP: exactly one cycle, then ACCESS with penable=1; paddr, pwrite and pwdata held.
- ACCESS:
  - Counter increments each cycle that pready=0.
  - If pready=1, sample in the same cycle:
    - rsp_rdata = prdata when read && !pslverr, else 0.
    - rsp_err = pslverr.
    - Next cycle: psel=0, penable=0, rsp_valid=1, state=RESP.
  - If TIMEOUT!=0 and counter reaches TIMEOUT with pready still 0: terminate the same way with rsp_err=1 and rsp_rdata=0.
  - pready and timeout in the same cycle: pready wins (normal completion).
- RESP:
  - rsp_valid, rsp_rdata and rsp_err held stable until rsp_ready=1.
  - Then rsp_valid=0, counter cleared, go to IDLE.
  - rsp_ready already high on the first RESP cycle gives a 1-cycle response.
- Latency:
  - Zero wait states: command accepted at edge N, psel=1 after N+1, penable=1 after N+2, rsp_valid=1 after N+3.
  - Each wait state adds 1 cycle.
  - Minimum issue period is 4 cycles per transfer (IDLE, SETUP, ACCESS, RESP).
- Bus idle:
  - paddr and pwdata keep their last values while psel=0.
  - pwrite returns to 0 in IDLE.
- No command queuing: cmd_valid while not IDLE is ignored and must be held by the client.

Test Plan:
- Write, zero wait: cmd write addr 0x0104 data 0x12345678 -> psel edge N+1, penable N+2 with paddr=0x0104, pwdata=0x12345678, pwrite=1; rsp_valid N+3, rsp_err=0, rsp_rdata=0.
- Read with 3 wait states: cmd read addr 0x0110; pready=0 for 3 ACCESS cycles, then 1 with prdata=0xA5A50001 -> penable high 4 cycles; rsp_rdata=0xA5A50001, rsp_err=0.
- Error and alignment: cmd read addr 0x0106, pslverr=1 with pready=1 -> paddr=0x0104; rsp_err=1, rsp_rdata=0.
- Timeout: TIMEOUT=16, pready stuck 0 -> exactly 16 ACCESS cycles, then psel=0; rsp_err=1, rsp_rdata=0; next command accepted normally.
- Response backpressure: rsp_ready low 5 cycles after rsp_valid -> rsp fields stable; cmd_ready=0 throughout; a back-to-back second command is accepted the cycle after the handshake.
- Async reset during ACCESS: assert rst mid-penable -> psel, penable and rsp_valid drop before the next pclk edge; after release cmd_ready=1 and no spurious response.
